cr_huf_comp_st_sched: RTL

Ping-pong scheduler for the Huffman compressor symbol-table buffers. It allocates a table buffer to the tree-walker for each frame, either coded or pass-thru, and tracks the STCL and ST LUT write phases. It presents completed buffers to the symbol assigner in allocation order and recycles each buffer on read-done. It sits between the tree-walker/LUT-write logic and the symbol assigner, so table build for frame N+1 overlaps with symbol assignment of frame N.

---
 rtl/cr_huf_comp_st_sched_pkg.sv | 22 ++
 rtl/cr_huf_comp_st_sched_buf_fsm.sv | 41 ++++
 rtl/cr_huf_comp_st_sched.sv | 107 ++++++++++
 3 files changed

// File: rtl/cr_huf_comp_st_sched_pkg.sv
// Shared types for the Huffman compressor symbol-table buffer scheduler.
package cr_huf_comp_st_sched_pkg;

   localparam int ST_SCHED_MAX_BUF = 4;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_STCL    = 2'd1,
      BUF_ST_WR   = 2'd2,
      BUF_TBL_RDY = 2'd3
   } e_st_buf_state;

   // A buffer is visible to the symbol assigner once its STCL phase is over.
   function automatic logic st_buf_readable(input e_st_buf_state s);
      return (s == BUF_ST_WR) || (s == BUF_TBL_RDY);
   endfunction

   function automatic logic st_buf_building(input e_st_buf_state s);
      return (s == BUF_STCL) || (s == BUF_ST_WR);
   endfunction

endpackage

// File: rtl/cr_huf_comp_st_sched_buf_fsm.sv
// Lifecycle of one symbol-table buffer: FREE -> (STCL) -> ST_WR -> TBL_RDY -> FREE.
module cr_huf_comp_st_buf_fsm
   import cr_huf_comp_st_sched_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_grant,
   input  logic          i_pass_thru,
   input  logic          i_stcl_done,
   input  logic          i_st_done,
   input  logic          i_read_done,
   output e_st_buf_state o_state,
   output logic          o_pass_thru
);

   e_st_buf_state r_state;
   logic          r_pass_thru;

   // Read-done has priority so a buffer released early never reverts to a build state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= BUF_FREE;
         r_pass_thru <= 1'b0;
      end else if (i_read_done) begin
         r_state <= BUF_FREE;
      end else if (i_grant && (r_state == BUF_FREE)) begin
         r_state     <= i_pass_thru ? BUF_ST_WR : BUF_STCL;
         r_pass_thru <= i_pass_thru;
      end else if (i_stcl_done && (r_state == BUF_STCL)) begin
         r_state <= BUF_ST_WR;
      end else if (i_st_done && (r_state == BUF_ST_WR)) begin
         r_state <= BUF_TBL_RDY;
      end else begin
         r_state <= r_state;
      end
   end

   assign o_state     = r_state;
   assign o_pass_thru = r_pass_thru;

endmodule

// File: rtl/cr_huf_comp_st_sched.sv
// Ping-pong allocator for symbol-table buffers between the tree-walker and the symbol assigner.
module cr_huf_comp_st_sched
   import cr_huf_comp_st_sched_pkg::*;
#(
   parameter  int NUM_BUF = 2,
   localparam int IDX_W   = $clog2(NUM_BUF)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tw_req_valid,
   input  logic             tw_req_pass_thru,
   output logic             tw_req_ready,
   output logic [IDX_W-1:0] tw_buf_idx,
   input  logic             st_stcl_lut_wr_done,
   input  logic             st_st_lut_wr_done,
   output logic             sa_tbl_valid,
   output logic             sa_tbl_rdy,
   output logic             sa_pass_thru,
   output logic [IDX_W-1:0] sa_buf_idx,
   input  logic             sa_st_read_done,
   output logic             sched_busy,
   output logic             sched_err
);

   localparam int                CNT_W    = $clog2(NUM_BUF + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BUF - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_BUF);

   logic [IDX_W-1:0] r_wr_ptr;
   logic [IDX_W-1:0] r_rd_ptr;
   logic [IDX_W-1:0] r_bld_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_err;

   e_st_buf_state    w_state [NUM_BUF];
   logic             w_pt    [NUM_BUF];
   e_st_buf_state    w_bld_state;
   e_st_buf_state    w_head_state;
   logic             w_building;
   logic             w_ready;
   logic             w_grant;
   logic             w_sa_valid;
   logic             w_stcl_ok;
   logic             w_st_ok;
   logic             w_rd_ok;

   assign w_bld_state  = w_state[r_bld_ptr];
   assign w_head_state = w_state[r_rd_ptr];
   assign w_building   = st_buf_building(w_bld_state);
   assign w_ready      = (r_count < FULL_CNT) && !w_building;
   assign w_grant      = tw_req_valid && w_ready;
   assign w_sa_valid   = st_buf_readable(w_head_state);
   assign w_stcl_ok    = st_stcl_lut_wr_done && (w_bld_state == BUF_STCL);
   assign w_st_ok      = st_st_lut_wr_done && (w_bld_state == BUF_ST_WR);
   assign w_rd_ok      = sa_st_read_done && w_sa_valid;

   for (genvar g = 0; g < NUM_BUF; g++) begin : g_buf
      cr_huf_comp_st_buf_fsm u_buf (
         .clk         (clk),
         .rst         (rst),
         .i_grant     (w_grant && (r_wr_ptr == IDX_W'(g))),
         .i_pass_thru (tw_req_pass_thru),
         .i_stcl_done (w_stcl_ok && (r_bld_ptr == IDX_W'(g))),
         .i_st_done   (w_st_ok && (r_bld_ptr == IDX_W'(g))),
         .i_read_done (w_rd_ok && (r_rd_ptr == IDX_W'(g))),
         .o_state     (w_state[g]),
         .o_pass_thru (w_pt[g])
      );
   end

   // Allocation order pointers, occupancy and the sticky protocol-error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_bld_ptr <= '0;
         r_count   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_grant) begin
            r_bld_ptr <= r_wr_ptr;
            r_wr_ptr  <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + IDX_W'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + IDX_W'(1);
         end
         case ({w_grant, w_rd_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if ((st_stcl_lut_wr_done && !w_stcl_ok) || (sa_st_read_done && !w_sa_valid)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign tw_req_ready = w_ready;
   assign tw_buf_idx   = w_building ? r_bld_ptr : r_wr_ptr;
   assign sa_tbl_valid = w_sa_valid;
   assign sa_tbl_rdy   = (w_head_state == BUF_TBL_RDY);
   assign sa_pass_thru = w_pt[r_rd_ptr];
   assign sa_buf_idx   = r_rd_ptr;
   assign sched_busy   = (r_count != '0);
   assign sched_err    = r_err;

endmodule
